// File: rtl/mac_rx_reader.sv
`default_nettype none
// ============================================================================
// Module   : mac_rx_reader
// Brief    : MAC receive-side reader feeding a FWFT FIFO and a packet stream.
// Revision : 1.0
// ============================================================================
module mac_rx_reader #(
    parameter int DEPTH     = 16,
    parameter int MAX_BYTES = 1522
) (
    input  logic        mac_clk_i,
    input  logic        mac_rst_n_i,
    input  logic [31:0] mac_rxd_i,
    input  logic [1:0]  mac_ben_i,
    input  logic        mac_rxda_i,
    input  logic        mac_rxsop_i,
    input  logic        mac_rxeop_i,
    input  logic        mac_rxdv_i,
    output logic        mac_rxrqrd_o,
    output logic [31:0] out_data_o,
    output logic [1:0]  out_ben_o,
    output logic        out_sop_o,
    output logic        out_eop_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        pkt_done_o,
    output logic [15:0] pkt_len_o,
    output logic        pkt_err_o,
    output logic [2:0]  err_sticky_o
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam int              c_EW       = 36;
    localparam logic [15:0]     c_MAX      = 16'(MAX_BYTES);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_CW:0]   c_RQ_LIMIT = (c_CW + 1)'(DEPTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RECV = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w_total;
        w_total = {1'b0, a} + {1'b0, b};
        return w_total[16] ? 16'hFFFF : w_total[15:0];
    endfunction

    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_next;
    logic [c_CW:0]   w_rq_level;
    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [15:0]     r_len;
    logic [15:0]     w_next_len;
    logic [15:0]     w_done_len;
    logic [15:0]     w_ben_bytes;
    logic [15:0]     w_start_bytes;
    logic [15:0]     w_sum;
    logic            r_rqrd;
    logic            r_rqrd_d;
    logic            r_pkt_done;
    logic            r_pkt_err;
    logic [15:0]     r_pkt_len;
    logic [2:0]      r_err_sticky;
    logic            w_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_attempt;
    logic            w_push;
    logic            w_ovf;
    logic            w_done;
    logic            w_done_err;
    logic            w_trunc;
    logic [c_EW-1:0] w_entry;
    logic [c_EW-1:0] w_head;

    assign w_valid       = (r_count != '0);
    assign w_full        = (r_count == c_FULL);
    assign w_pop         = w_valid & out_ready_i;
    assign w_ben_bytes   = (mac_ben_i == 2'b00) ? 16'd4 : {14'd0, mac_ben_i};
    assign w_start_bytes = mac_rxeop_i ? w_ben_bytes : 16'd4;
    assign w_sum         = sat_add(r_len, w_start_bytes);
    assign w_entry       = {mac_rxeop_i, mac_rxsop_i, (mac_rxeop_i ? mac_ben_i : 2'b00), mac_rxd_i};
    assign w_head        = r_mem[r_rd_ptr];

    // Capture decision; words that would push the byte count past MAX_BYTES are never written.
    always_comb begin
        w_attempt    = 1'b0;
        w_ovf        = 1'b0;
        w_push       = 1'b0;
        w_trunc      = 1'b0;
        w_done       = 1'b0;
        w_done_err   = 1'b0;
        w_done_len   = r_len;
        w_next_len   = r_len;
        w_next_state = r_state;
        if (mac_rxdv_i) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (mac_rxsop_i) begin
                        w_attempt    = 1'b1;
                        w_next_len   = w_start_bytes;
                        w_done_len   = w_start_bytes;
                        w_done       = mac_rxeop_i;
                        w_next_state = mac_rxeop_i ? c_ST_IDLE : c_ST_RECV;
                    end
                end
                c_ST_RECV, c_ST_DROP: begin
                    if (mac_rxsop_i) begin
                        w_trunc      = 1'b1;
                        w_done       = 1'b1;
                        w_done_err   = 1'b1;
                        w_attempt    = 1'b1;
                        w_next_len   = w_start_bytes;
                        w_next_state = mac_rxeop_i ? c_ST_IDLE : c_ST_RECV;
                    end else begin
                        w_next_len = w_sum;
                        w_done_len = w_sum;
                        w_done     = mac_rxeop_i;
                        if ((r_state == c_ST_RECV) && (w_sum <= c_MAX)) begin
                            w_attempt    = 1'b1;
                            w_next_state = mac_rxeop_i ? c_ST_IDLE : c_ST_RECV;
                        end else begin
                            w_done_err   = mac_rxeop_i;
                            w_next_state = mac_rxeop_i ? c_ST_IDLE : c_ST_DROP;
                        end
                    end
                end
                default: w_next_state = c_ST_IDLE;
            endcase
        end
        w_ovf  = w_attempt & w_full & ~w_pop;
        w_push = w_attempt & ~w_ovf;
        if (w_ovf) begin
            w_done_err   = w_done;
            w_next_state = mac_rxeop_i ? c_ST_IDLE : c_ST_DROP;
        end
    end

    assign w_count_next = r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
    // The word requested last cycle is still unaccounted for in the next count.
    assign w_rq_level   = {1'b0, w_count_next} + {{c_CW{1'b0}}, r_rqrd};

    always_ff @(posedge mac_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge mac_clk_i or negedge mac_rst_n_i) begin
        if (!mac_rst_n_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= c_ST_IDLE;
            r_len        <= '0;
            r_rqrd       <= 1'b0;
            r_rqrd_d     <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_pkt_len    <= '0;
            r_err_sticky <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count      <= w_count_next;
            r_state      <= w_next_state;
            r_len        <= w_next_len;
            r_rqrd       <= mac_rxda_i & (w_rq_level <= c_RQ_LIMIT);
            r_rqrd_d     <= r_rqrd;
            r_pkt_done   <= w_done;
            r_pkt_err    <= w_done & w_done_err;
            if (w_done) begin
                r_pkt_len <= w_done_len;
            end
            r_err_sticky <= r_err_sticky | {mac_rxdv_i & ~r_rqrd_d, w_ovf, w_trunc};
        end
    end

    assign mac_rxrqrd_o = r_rqrd;
    assign out_valid_o  = w_valid;
    assign out_data_o   = w_valid ? w_head[31:0]  : 32'd0;
    assign out_ben_o    = w_valid ? w_head[33:32] : 2'd0;
    assign out_sop_o    = w_valid & w_head[34];
    assign out_eop_o    = w_valid & w_head[35];
    assign pkt_done_o   = r_pkt_done;
    assign pkt_len_o    = r_pkt_len;
    assign pkt_err_o    = r_pkt_err;
    assign err_sticky_o = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_mac_rx_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_rx_reader
// Brief    : Self-checking bench for mac_rx_reader with a MAC responder model.
// Revision : 1.0
// ============================================================================
module tb_mac_rx_reader;

    localparam int DEPTH     = 16;
    localparam int MAX_BYTES = 64;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  ben;
    } word_t;

    typedef struct packed {
        logic [15:0] len;
        logic        err;
    } rep_t;

    typedef struct {
        int         n;
        logic [1:0] ben;
        int         exp_words;
        int         exp_len;
        bit         exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rxd = '0;
    logic [1:0]  ben = '0;
    logic        rxda = 1'b0;
    logic        rxsop = 1'b0;
    logic        rxeop = 1'b0;
    logic        rxdv = 1'b0;
    logic        rqrd;
    logic [31:0] out_data;
    logic [1:0]  out_ben;
    logic        out_sop;
    logic        out_eop;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        pkt_done;
    logic [15:0] pkt_len;
    logic        pkt_err;
    logic [2:0]  err_sticky;

    mac_rx_reader #(.DEPTH(DEPTH), .MAX_BYTES(MAX_BYTES)) dut (
        .mac_clk_i   (clk),
        .mac_rst_n_i (rst_n),
        .mac_rxd_i   (rxd),
        .mac_ben_i   (ben),
        .mac_rxda_i  (rxda),
        .mac_rxsop_i (rxsop),
        .mac_rxeop_i (rxeop),
        .mac_rxdv_i  (rxdv),
        .mac_rxrqrd_o(rqrd),
        .out_data_o  (out_data),
        .out_ben_o   (out_ben),
        .out_sop_o   (out_sop),
        .out_eop_o   (out_eop),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pkt_done_o  (pkt_done),
        .pkt_len_o   (pkt_len),
        .pkt_err_o   (pkt_err),
        .err_sticky_o(err_sticky)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    word_t       mac_q[$];
    word_t       got_s[$];
    word_t       exp_s[$];
    rep_t        got_r[$];
    rep_t        exp_r[$];
    bit          prev_rq = 1'b0;
    bit          prev_rxda = 1'b0;
    int          ready_mode = 0;
    bit          inj_valid = 1'b0;
    word_t       inj_w;
    int          cyc = 0;
    int          eop_dv_cyc = 0, done_cyc = 0, eop_pop_cyc = 0;
    int          first_dv_cyc = -1, last_dv_cyc = 0;
    int          rxda_rise = 0, rxda_fall = 0, rq_rise = 0, rq_fall = 0;
    int          hold_viol = 0;
    logic [15:0] last_len = '0;
    vec_t        tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input word_t w);
        rxdv  = 1'b1;
        rxd   = w.data;
        rxsop = w.sop;
        rxeop = w.eop;
        ben   = w.ben;
        if (w.eop) eop_dv_cyc = cyc;
        if (first_dv_cyc < 0) first_dv_cyc = cyc;
        last_dv_cyc = cyc;
    endtask

    // One clock cycle: MAC responder answers last cycle's request, stream monitor records pops.
    task automatic tick();
        word_t w;
        bit    cur_rq;
        @(posedge clk);
        #1;
        cyc++;
        cur_rq = rqrd;
        if (cur_rq && !prev_rq) rq_rise = cyc;
        if (!cur_rq && prev_rq) rq_fall = cyc;
        if (inj_valid) begin
            drive(inj_w);
            inj_valid = 1'b0;
        end else if (prev_rq && mac_q.size() > 0) begin
            w = mac_q.pop_front();
            drive(w);
        end else begin
            rxdv  = 1'b0;
            rxd   = $urandom;
            ben   = 2'($urandom);
            rxsop = 1'($urandom);
            rxeop = 1'($urandom);
        end
        rxda = (mac_q.size() > 0);
        if (rxda && !prev_rxda) rxda_rise = cyc;
        if (!rxda && prev_rxda) rxda_fall = cyc;
        prev_rxda = rxda;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        prev_rq = cur_rq;
        if (out_valid && out_ready) begin
            w = {out_data, out_sop, out_eop, out_ben};
            got_s.push_back(w);
            if (out_eop) eop_pop_cyc = cyc;
        end
        if (pkt_done) begin
            got_r.push_back({pkt_len, pkt_err});
            done_cyc = cyc;
        end else if (pkt_len !== last_len) begin
            hold_viol++;
        end
        last_len = pkt_len;
    endtask

    // Reference: a packet's words are forwarded while its running byte total stays within MAX_BYTES.
    task automatic send_pkt(input int n, input logic [1:0] eben);
        word_t w, e;
        rep_t  r;
        int    bytes;
        bit    over;
        bytes = 0;
        over  = 1'b0;
        for (int i = 0; i < n; i++) begin
            w.data = $urandom;
            w.sop  = (i == 0);
            w.eop  = (i == n - 1);
            w.ben  = w.eop ? eben : 2'($urandom);
            mac_q.push_back(w);
            bytes += w.eop ? ((eben == 2'b00) ? 4 : int'(eben)) : 4;
            if (bytes > MAX_BYTES) over = 1'b1;
            if (!over) begin
                e = w;
                e.ben = w.eop ? eben : 2'b00;
                exp_s.push_back(e);
            end
        end
        r.len = (bytes > 65535) ? 16'hFFFF : 16'(bytes);
        r.err = over;
        exp_r.push_back(r);
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while (!(mac_q.size() == 0 && got_s.size() >= exp_s.size() && got_r.size() >= exp_r.size())
               && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check("idle_timeout", 64'(k), 64'(0));
        repeat (4) tick();
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nwords"}, 64'(got_s.size()), 64'(exp_s.size()));
        check({tag, "_nreps"}, 64'(got_r.size()), 64'(exp_r.size()));
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++)
            check({tag, "_word"}, 64'(got_s[i]), 64'(exp_s[i]));
        for (int i = 0; i < got_r.size() && i < exp_r.size(); i++)
            check({tag, "_rep"}, 64'(got_r[i]), 64'(exp_r[i]));
        got_s.delete();
        exp_s.delete();
        got_r.delete();
        exp_r.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w, e;
        rep_t  r;
        int    sent;
        int    k;

        tbl[0] = '{1,  2'd0, 1,  4,  1'b0};
        tbl[1] = '{1,  2'd1, 1,  1,  1'b0};
        tbl[2] = '{1,  2'd2, 1,  2,  1'b0};
        tbl[3] = '{1,  2'd3, 1,  3,  1'b0};
        tbl[4] = '{2,  2'd3, 2,  7,  1'b0};
        tbl[5] = '{3,  2'd2, 3,  10, 1'b0};
        tbl[6] = '{16, 2'd0, 16, 64, 1'b0};
        tbl[7] = '{17, 2'd1, 16, 65, 1'b1};
        tbl[8] = '{20, 2'd0, 16, 80, 1'b1};

        // Reset state
        repeat (3) tick();
        check("reset_outputs",
              64'({rqrd, out_data, out_ben, out_sop, out_eop, out_valid, pkt_done, pkt_len, pkt_err, err_sticky}),
              64'(0));
        #2 rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven packet shapes including the MAX_BYTES boundary
        ready_mode = 0;
        for (int i = 0; i < 9; i++) begin
            send_pkt(tbl[i].n, tbl[i].ben);
            run_until_idle(200);
            check("tbl_nreps", 64'(got_r.size()), 64'(1));
            check("tbl_nwords", 64'(got_s.size()), 64'(tbl[i].exp_words));
            if (got_r.size() > 0) begin
                check("tbl_len", 64'(got_r[0].len), 64'(tbl[i].exp_len));
                check("tbl_err", 64'(got_r[0].err), 64'(tbl[i].exp_err));
            end
            compare_all("tbl");
        end

        // Single 5-word packet: latency, throughput and request timing
        first_dv_cyc = -1;
        send_pkt(5, 2'd2);
        run_until_idle(100);
        check("single_done_lat", 64'(done_cyc), 64'(eop_dv_cyc + 1));
        check("single_fwft_lat", 64'(eop_pop_cyc), 64'(eop_dv_cyc + 1));
        check("single_throughput", 64'(last_dv_cyc - first_dv_cyc), 64'(4));
        check("single_rq_rise", 64'(rq_rise), 64'(rxda_rise + 1));
        check("single_rq_fall", 64'(rq_fall), 64'(rxda_fall + 1));
        if (got_r.size() > 0) check("single_len", 64'({got_r[0].len, got_r[0].err}), 64'({16'd18, 1'b0}));
        if (got_s.size() == 5) begin
            check("single_first_sop", 64'({got_s[0].sop, got_s[0].eop}), 64'(2'b10));
            check("single_last_eop", 64'({got_s[4].sop, got_s[4].eop, got_s[4].ben}), 64'(4'b0110));
        end
        compare_all("single");

        // Backpressure: FIFO fills to exactly DEPTH without overflow
        ready_mode = 2;
        for (int i = 0; i < 5; i++) send_pkt(4, 2'd0);
        repeat (60) tick();
        check("bp_rqrd_low", 64'(rqrd), 64'(0));
        check("bp_nothing_out", 64'(got_s.size()), 64'(0));
        check("bp_mac_left", 64'(mac_q.size()), 64'(4));
        check("bp_valid", 64'(out_valid), 64'(1));
        check("bp_sticky", 64'(err_sticky), 64'(0));
        ready_mode = 0;
        run_until_idle(200);
        compare_all("bp");

        // Truncation: sop, 2 words, new sop, eop
        for (int i = 0; i < 5; i++) begin
            w.data = $urandom;
            w.sop  = (i == 0 || i == 3);
            w.eop  = (i == 4);
            w.ben  = (i == 4) ? 2'b00 : 2'($urandom);
            mac_q.push_back(w);
            e = w;
            e.ben = 2'b00;
            exp_s.push_back(e);
        end
        r = '{16'd12, 1'b1};
        exp_r.push_back(r);
        r = '{16'd8, 1'b0};
        exp_r.push_back(r);
        run_until_idle(100);
        compare_all("trunc");
        check("trunc_sticky", 64'(err_sticky), 64'(3'b001));

        // Unsolicited rxdv
        inj_w = {32'hA5C3_0F1E, 1'b1, 1'b1, 2'b11};
        inj_valid = 1'b1;
        exp_s.push_back(inj_w);
        r = '{16'd3, 1'b0};
        exp_r.push_back(r);
        run_until_idle(50);
        compare_all("unsol");
        check("unsol_sticky", 64'(err_sticky), 64'(3'b101));

        // Reset mid-packet
        ready_mode = 2;
        for (int i = 0; i < 3; i++) begin
            w.data = $urandom;
            w.sop  = (i == 0);
            w.eop  = 1'b0;
            w.ben  = 2'b00;
            mac_q.push_back(w);
        end
        repeat (6) tick();
        check("rstmid_pre_valid", 64'(out_valid), 64'(1));
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_outputs",
              64'({rqrd, out_data, out_ben, out_sop, out_eop, out_valid, pkt_done, pkt_len, pkt_err, err_sticky}),
              64'(0));
        mac_q.delete();
        got_s.delete();
        got_r.delete();
        prev_rq = 1'b0;
        last_len = '0;
        rxdv = 1'b0;
        rxda = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b1;
        ready_mode = 0;
        send_pkt(4, 2'd1);
        run_until_idle(100);
        compare_all("rstmid_clean");

        // Randomized traffic against the packet-level model
        ready_mode = 1;
        sent = 0;
        k = 0;
        while (k < 30000 && !(sent == 80 && mac_q.size() == 0 &&
                              got_s.size() >= exp_s.size() && got_r.size() >= exp_r.size())) begin
            if (sent < 80 && mac_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                send_pkt($urandom_range(1, 20), 2'($urandom));
                sent++;
            end
            tick();
            k++;
        end
        if (k >= 30000) check("rand_timeout", 64'(k), 64'(0));
        repeat (6) tick();
        compare_all("rand");
        check("rand_sticky", 64'(err_sticky), 64'(0));
        check("len_hold", 64'(hold_viol), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
